ram: RTL and testbench

//  Simple dual-port synchronous RAM: one write port, one read port, one clock.

---
 rtl/ram.sv | 95 +++++++++
 tb/tb_ram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// rtl/ram.sv - simple dual-port synchronous RAM, 1 or 2 cycle read latency, optional RAM_RDW_BYPASS_EN
module ram #(
    parameter int    ADDR_WIDTH = 10,
    parameter int    DATA_WIDTH = 32,
    parameter int    OUTPUT_REG = 0,
    parameter string TYPE       = "block"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_write_req,
    input  logic [ADDR_WIDTH-1:0] s_write_addr,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    input  logic                  s_read_req,
    input  logic [ADDR_WIDTH-1:0] s_read_addr,
    output logic [DATA_WIDTH-1:0] s_read_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rdw_hit;

    // Collision between the read and write port this cycle.
    assign rdw_hit = s_write_req && (s_write_addr == s_read_addr);

    // The storage array lives inside the branch so the ram_style attribute can
    // carry the implementation hint; both branches are functionally identical.
    generate
        if (TYPE == "distributed") begin : g_dist
            (* ram_style = "distributed" *)
            logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Write port (never reset) and registered read port.
            always_ff @(posedge clk) begin
                if (s_write_req) begin
                    mem[s_write_addr] <= s_write_data;
                end
                if (reset) begin
                    rd_q <= '0;
                end else if (s_read_req) begin
`ifdef RAM_RDW_BYPASS_EN
                    rd_q <= rdw_hit ? s_write_data : mem[s_read_addr];
`else
                    rd_q <= mem[s_read_addr];
`endif
                end
            end
        end else begin : g_block
            (* ram_style = "block" *)
            logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Write port (never reset) and registered read port.
            always_ff @(posedge clk) begin
                if (s_write_req) begin
                    mem[s_write_addr] <= s_write_data;
                end
                if (reset) begin
                    rd_q <= '0;
                end else if (s_read_req) begin
`ifdef RAM_RDW_BYPASS_EN
                    rd_q <= rdw_hit ? s_write_data : mem[s_read_addr];
`else
                    rd_q <= mem[s_read_addr];
`endif
                end
            end
        end
    endgenerate

`ifndef RAM_RDW_BYPASS_EN
    // Without forwarding the collision flag has no consumer.
    logic unused_rdw;
    assign unused_rdw = rdw_hit;
`endif

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;

            // Extra pipeline stage, free-running every cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end

            assign s_read_data = out_q;
        end else begin : g_no_out_reg
            assign s_read_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - directed self-checking bench for ram
module tb_ram;

    parameter int OUTPUT_REG = 0;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_write_req;
    logic [AW-1:0] s_write_addr;
    logic [DW-1:0] s_write_data;
    logic          s_read_req;
    logic [AW-1:0] s_read_addr;
    logic [DW-1:0] s_read_data;

    int n_cmp = 0;
    int n_err = 0;

    ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .OUTPUT_REG (OUTPUT_REG),
        .TYPE       ("block")
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_write_req  (s_write_req),
        .s_write_addr (s_write_addr),
        .s_write_data (s_write_data),
        .s_read_req   (s_read_req),
        .s_read_addr  (s_read_addr),
        .s_read_data  (s_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_write_req  = 1'b0;
        s_read_req   = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_write_req  = 1'b1;
        s_write_addr = a;
        s_write_data = d;
        step();
        s_write_req  = 1'b0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
        s_read_req  = 1'b1;
        s_read_addr = a;
        step();
        s_read_req  = 1'b0;
        repeat (OUTPUT_REG) step();
        d = s_read_data;
    endtask

    logic [DW-1:0] rd;
    logic [DW-1:0] exp_rdw;

    initial begin
        reset        = 1'b1;
        s_write_req  = 1'b0;
        s_write_addr = '0;
        s_write_data = '0;
        s_read_req   = 1'b0;
        s_read_addr  = '0;

        // 1: reset for two cycles, output cleared
        step();
        step();
        reset = 1'b0;
        check("reset_out", s_read_data, 32'h0);

        // 2: write then read, latency check
        write_word(10'h005, 32'hDEADBEEF);
        s_read_req  = 1'b1;
        s_read_addr = 10'h005;
        step();
        s_read_req  = 1'b0;
        if (OUTPUT_REG != 0) begin
            check("latency_early", s_read_data, 32'h0);
            step();
        end
        check("wr_rd_005", s_read_data, 32'hDEADBEEF);

        // 4: output holds while no read is requested
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_%0d", i), s_read_data, 32'hDEADBEEF);
        end

        // read and write at different addresses in the same cycle
        s_write_req  = 1'b1;
        s_write_addr = 10'h006;
        s_write_data = 32'hCAFEF00D;
        s_read_req   = 1'b1;
        s_read_addr  = 10'h005;
        step();
        idle();
        repeat (OUTPUT_REG) step();
        check("diff_addr_rd", s_read_data, 32'hDEADBEEF);
        read_word(10'h006, rd);
        check("diff_addr_wr", rd, 32'hCAFEF00D);

        // 5: same-address collision
`ifdef RAM_RDW_BYPASS_EN
        exp_rdw = 32'h12345678;
`else
        exp_rdw = 32'hDEADBEEF;
`endif
        s_write_req  = 1'b1;
        s_write_addr = 10'h005;
        s_write_data = 32'h12345678;
        s_read_req   = 1'b1;
        s_read_addr  = 10'h005;
        step();
        idle();
        repeat (OUTPUT_REG) step();
        check("rdw_collision", s_read_data, exp_rdw);
        read_word(10'h005, rd);
        check("rdw_after", rd, 32'h12345678);

        // 6: reset between request and data; write during reset still lands
        s_read_req  = 1'b1;
        s_read_addr = 10'h005;
        step();
        s_read_req   = 1'b0;
        reset        = 1'b1;
        s_write_req  = 1'b1;
        s_write_addr = 10'h3FF;
        s_write_data = 32'hA5A5_5A5A;
        step();
        idle();
        check("reset_midread", s_read_data, 32'h0);
        s_read_req  = 1'b1;
        s_read_addr = 10'h006;
        step();
        s_read_req = 1'b0;
        reset      = 1'b0;
        check("read_in_reset_dropped", s_read_data, 32'h0);
        step();
        check("read_in_reset_dropped2", s_read_data, 32'h0);
        read_word(10'h005, rd);
        check("retained_005", rd, 32'h12345678);
        read_word(10'h3FF, rd);
        check("write_in_reset", rd, 32'hA5A5_5A5A);

        // 3: fill the whole array, then stream reads back-to-back
        for (int k = 0; k < 1024; k++) begin
            s_write_req  = 1'b1;
            s_write_addr = AW'(k);
            s_write_data = DW'(k * 3);
            step();
        end
        s_write_req = 1'b0;
        for (int i = 0; i < 1024 + OUTPUT_REG; i++) begin
            s_read_req  = (i < 1024);
            s_read_addr = AW'(i);
            step();
            if (i >= OUTPUT_REG) begin
                check($sformatf("sweep_%03h", i - OUTPUT_REG), s_read_data, DW'((i - OUTPUT_REG) * 3));
            end
        end
        s_read_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
